// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and helpers for the register file slice
package reg_file_pkg;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write bits with set/clear and two lookups
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          Reset_n,
    input  logic          set,
    input  logic [AW-1:0] set_addr,
    input  logic          clear,
    input  logic [AW-1:0] clear_addr,
    input  logic [AW-1:0] look1,
    input  logic [AW-1:0] look2,
    output logic          busy1,
    output logic          busy2
);
    logic [DEPTH-1:0] busy;

    // Set beats clear when both hit the same register in one edge.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (set && set_addr == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clear && clear_addr == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Addresses beyond DEPTH match no entry and therefore read as not busy.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (look1 == AW'(i)) busy1 = busy[i];
            if (look2 == AW'(i)) busy2 = busy[i];
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-read one-write register file with registered reads and busy scoreboard
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = INIT_INDEX
) (
    input  logic                          clock,
    input  logic                          Reset_n,
    input  logic [addr_width(DEPTH)-1:0]  Read1,
    input  logic [addr_width(DEPTH)-1:0]  Read2,
    input  logic                          ReadEn,
    output logic [WIDTH-1:0]              Data1,
    output logic [WIDTH-1:0]              Data2,
    output logic                          Valid1,
    output logic                          Valid2,
    input  logic [addr_width(DEPTH)-1:0]  WriteReg,
    input  logic [WIDTH-1:0]              WriteData,
    input  logic                          RegWrite,
    input  logic [addr_width(DEPTH)-1:0]  BusyReg,
    input  logic                          BusySet
);
    localparam int            AW        = addr_width(DEPTH);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] rf [DEPTH];
    logic             wr_ok;
    logic             set_ok;
    logic             busy1;
    logic             busy2;
    logic [WIDTH-1:0] nxt_data1;
    logic [WIDTH-1:0] nxt_data2;
    logic             nxt_valid1;
    logic             nxt_valid2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok  = RegWrite && in_range(WriteReg) && !is_zero(WriteReg);
    assign set_ok = BusySet && in_range(BusyReg) && !is_zero(BusyReg);

    reg_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clock      (clock),
        .Reset_n    (Reset_n),
        .set        (set_ok),
        .set_addr   (BusyReg),
        .clear      (wr_ok),
        .clear_addr (WriteReg),
        .look1      (Read1),
        .look2      (Read2),
        .busy1      (busy1),
        .busy2      (busy2)
    );

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= (INIT_MODE == INIT_INDEX && !(ZERO_REG != 0 && i == 0)) ? WIDTH'(i) : '0;
            end
        end else if (wr_ok) begin
            rf[WriteReg] <= WriteData;
        end
    end

    // A same-edge write wins over stored data and over any busy state, set included.
    always_comb begin
        nxt_data1  = rf[Read1];
        nxt_valid1 = ~busy1;
        if (!in_range(Read1) || is_zero(Read1)) begin
            nxt_data1  = '0;
            nxt_valid1 = 1'b1;
        end else if (wr_ok && WriteReg == Read1) begin
            nxt_data1  = WriteData;
            nxt_valid1 = 1'b1;
        end

        nxt_data2  = rf[Read2];
        nxt_valid2 = ~busy2;
        if (!in_range(Read2) || is_zero(Read2)) begin
            nxt_data2  = '0;
            nxt_valid2 = 1'b1;
        end else if (wr_ok && WriteReg == Read2) begin
            nxt_data2  = WriteData;
            nxt_valid2 = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Data1  <= '0;
            Data2  <= '0;
            Valid1 <= 1'b0;
            Valid2 <= 1'b0;
        end else if (ReadEn) begin
            Data1  <= nxt_data1;
            Data2  <= nxt_data2;
            Valid1 <= nxt_valid1;
            Valid2 <= nxt_valid2;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard-driven self-checking bench for reg_file_sb
module tb_reg_file_sb;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clock = 1'b0;
    logic             Reset_n = 1'b0;
    logic [AW-1:0]    Read1 = '0;
    logic [AW-1:0]    Read2 = '0;
    logic             ReadEn = 1'b0;
    logic [WIDTH-1:0] Data1;
    logic [WIDTH-1:0] Data2;
    logic             Valid1;
    logic             Valid2;
    logic [AW-1:0]    WriteReg = '0;
    logic [WIDTH-1:0] WriteData = '0;
    logic             RegWrite = 1'b0;
    logic [AW-1:0]    BusyReg = '0;
    logic             BusySet = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] d1;
        logic             v1;
        logic [WIDTH-1:0] d2;
        logic             v2;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             last_exp;
    logic [WIDTH-1:0] m_rf [DEPTH];
    logic             m_busy [DEPTH];
    int               total = 0;
    int               bad = 0;

    reg_file_sb #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ZERO_REG  (1),
        .INIT_MODE (1)
    ) dut (
        .clock     (clock),
        .Reset_n   (Reset_n),
        .Read1     (Read1),
        .Read2     (Read2),
        .ReadEn    (ReadEn),
        .Data1     (Data1),
        .Data2     (Data2),
        .Valid1    (Valid1),
        .Valid2    (Valid2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .BusyReg   (BusyReg),
        .BusySet   (BusySet)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rf[i]   = WIDTH'(i);
            m_busy[i] = 1'b0;
        end
        last_exp = '0;
        exp_q.delete();
    endtask

    // {valid, data} a read of address a should capture at the coming edge
    function automatic logic [WIDTH:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return {1'b1, {WIDTH{1'b0}}};
        if (RegWrite && WriteReg == a) return {1'b1, WriteData};
        return {~m_busy[a], m_rf[a]};
    endfunction

    task automatic step(input string tag);
        exp_t           e;
        logic [WIDTH:0] r1;
        logic [WIDTH:0] r2;
        if (ReadEn) begin
            r1 = m_read(Read1);
            r2 = m_read(Read2);
            e  = {r1[WIDTH-1:0], r1[WIDTH], r2[WIDTH-1:0], r2[WIDTH]};
        end else begin
            e = last_exp;
        end
        exp_q.push_back(e);
        last_exp = e;
        if (RegWrite && WriteReg != 0) begin
            m_rf[WriteReg]   = WriteData;
            m_busy[WriteReg] = 1'b0;
        end
        if (BusySet && BusyReg != 0) m_busy[BusyReg] = 1'b1;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, ".data1"},  64'(Data1),  64'(e.d1));
        check({tag, ".valid1"}, 64'(Valid1), 64'(e.v1));
        check({tag, ".data2"},  64'(Data2),  64'(e.d2));
        check({tag, ".valid2"}, 64'(Valid2), 64'(e.v2));
        @(negedge clock);
    endtask

    task automatic drive(input logic re, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic rw, input logic [AW-1:0] wr, input logic [WIDTH-1:0] wd,
                         input logic bs, input logic [AW-1:0] br);
        ReadEn = re; Read1 = r1; Read2 = r2;
        RegWrite = rw; WriteReg = wr; WriteData = wd;
        BusySet = bs; BusyReg = br;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check("reset.data1",  64'(Data1),  64'h0);
        check("reset.valid2", 64'(Valid2), 64'h0);
        Reset_n = 1'b1;

        drive(1, 5, 31, 0, 0, 0, 0, 0);                  step("init_read");
        drive(1, 7, 2, 1, 7, 32'hDEADBEEF, 0, 0);        step("bypass7");
        drive(1, 7, 7, 0, 0, 0, 0, 0);                   step("read7");
        drive(0, 0, 0, 0, 0, 0, 1, 9);                   step("busy9");
        drive(1, 9, 8, 0, 0, 0, 0, 0);                   step("read9_busy");
        drive(0, 1, 1, 1, 9, 32'h55, 0, 0);              step("hold_write9");
        drive(1, 9, 9, 0, 0, 0, 0, 0);                   step("read9_done");
        drive(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0);        step("zero_wr");
        drive(1, 0, 0, 0, 0, 0, 0, 0);                   step("zero_read");
        drive(1, 3, 4, 1, 3, 32'h1234, 1, 3);            step("set_wins");
        drive(1, 3, 3, 0, 0, 0, 0, 0);                   step("read3_busy");
        drive(1, 11, 11, 0, 0, 0, 1, 11);                step("set_same_edge");
        drive(1, 11, 12, 0, 0, 0, 0, 0);                 step("read11_busy");

        for (int n = 0; n < 150; n++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
            step("rand");
        end

        // In-flight write to 7 and BusySet on 5 are cut off by a reset mid-cycle.
        drive(1, 7, 5, 1, 7, 32'hCAFEF00D, 1, 5);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst.data1",  64'(Data1),  64'h0);
        check("async_rst.valid1", 64'(Valid1), 64'h0);
        check("async_rst.data2",  64'(Data2),  64'h0);
        check("async_rst.valid2", 64'(Valid2), 64'h0);
        model_reset();
        @(posedge clock);
        #2;
        Reset_n = 1'b1;
        @(negedge clock);
        drive(1, 7, 5, 0, 0, 0, 0, 0);                   step("post_rst");
        drive(1, 31, 0, 0, 0, 0, 0, 0);                  step("post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
